// File: rtl/play_reporter_pkg.sv
// play_reporter_pkg: shared constants, button-to-ASCII table, transmit FSM
// state encoding and message-length helper for play_reporter.
package play_reporter_pkg;

   localparam logic [6:0] ASCII_HASH   = 7'h23;
   localparam logic [6:0] ASCII_DOLLAR = 7'h24;
   localparam logic [6:0] ASCII_ZERO   = 7'h30;

   localparam int BTN_TABLE_SIZE = 16;

   // Button index -> ASCII. Index 0 is the highest-priority button.
   localparam logic [6:0] BTN_ASCII [0:BTN_TABLE_SIZE-1] = '{
      7'h4A, 7'h5A, 7'h59, 7'h52,   // J Z Y R
      7'h4C, 7'h41, 7'h42, 7'h43,   // L A B C
      7'h44, 7'h45, 7'h46, 7'h47,   // D E F G
      7'h48, 7'h49, 7'h4B, 7'h4D    // H I K M
   };

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_NEXT  = 3'd4
   } tx_state_e;

   // Message is <btn> '$' <digits> '#'.
   function automatic int msg_len(input int pos_digits);
      return pos_digits + 3;
   endfunction

endpackage

// File: rtl/tx_serial_7E1.sv
// tx_serial_7E1: one-character 7E1 serial transmitter.
// Frame = start(0), 7 data bits LSB first, even parity, stop(1).
// A 'partida' pulse while idle launches a frame; 'pronto' pulses for one
// cycle once the stop bit has completed. The line idles high.
module tx_serial_7E1 #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       partida,
   input  logic [6:0] dados_ascii,
   output logic       saida_serial,
   output logic       pronto
);

   localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic              active_q, active_d;
   logic [9:0]        shift_q, shift_d;
   logic [3:0]        bit_q, bit_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic              serial_q, serial_d;
   logic              pronto_q, pronto_d;

   // Next-state: load a frame on partida, then step one bit per bit period.
   always_comb begin
      active_d = active_q;
      shift_d  = shift_q;
      bit_d    = bit_q;
      tick_d   = tick_q;
      serial_d = serial_q;
      pronto_d = 1'b0;
      if (!active_q) begin
         serial_d = 1'b1;
         if (partida) begin
            shift_d  = {1'b1, ^dados_ascii, dados_ascii, 1'b0};
            serial_d = 1'b0;
            active_d = 1'b1;
            bit_d    = 4'd0;
            tick_d   = '0;
         end else begin
            shift_d = shift_q;
         end
      end else begin
         if (tick_q == TICK_W'(CLKS_PER_BIT - 1)) begin
            tick_d = '0;
            if (bit_q == 4'd9) begin
               active_d = 1'b0;
               serial_d = 1'b1;
               pronto_d = 1'b1;
            end else begin
               bit_d    = bit_q + 4'd1;
               shift_d  = {1'b1, shift_q[9:1]};
               serial_d = shift_q[1];
            end
         end else begin
            tick_d = tick_q + 1'b1;
         end
      end
   end

   // State register with synchronous reset; line forced high on reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         active_q <= 1'b0;
         shift_q  <= 10'h3FF;
         bit_q    <= 4'd0;
         tick_q   <= '0;
         serial_q <= 1'b1;
         pronto_q <= 1'b0;
      end else begin
         active_q <= active_d;
         shift_q  <= shift_d;
         bit_q    <= bit_d;
         tick_q   <= tick_d;
         serial_q <= serial_d;
         pronto_q <= pronto_d;
      end
   end

   assign saida_serial = serial_q;
   assign pronto       = pronto_q;

endmodule

// File: rtl/play_reporter.sv
// play_reporter: captures a player action (one-hot buttons + position),
// formats it as "<btn>$<digits>#", optionally compares it against an
// expected message, queues it and transmits it over a 7E1 serial line.
// Optional feature macro: PLAY_REPORTER_CHECK_EN (comparator and
// acertou/acertou_valid registers; when undefined both outputs are 0).
module play_reporter
   import play_reporter_pkg::*;
#(
   parameter int N_BUTTONS   = 9,
   parameter int POS_W       = 4,
   parameter int POS_DIGITS  = 2,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               registra,
   input  logic [N_BUTTONS-1:0]               botoes,
   input  logic [POS_W-1:0]                   pos,
   input  logic [7*(POS_DIGITS+3)-1:0]        expected,
   output logic                               serial,
   output logic                               busy,
   output logic [7*(POS_DIGITS+3)-1:0]        resposta,
   output logic                               acertou,
   output logic                               acertou_valid,
   output logic                               overflow,
   output logic [$clog2(QUEUE_DEPTH):0]       ocupacao
);

   localparam int MSG_LEN = msg_len(POS_DIGITS);
   localparam int MSG_W   = 7 * MSG_LEN;
   localparam int PTR_W   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CNT_W   = $clog2(QUEUE_DEPTH) + 1;
   localparam int IDX_W   = $clog2(MSG_LEN);
   localparam int ENT_W   = 7 + POS_W;

   // Character c sits at bits [(MSG_LEN-1-c)*7 +: 7]; character 0 in MSBs.
   function automatic logic [MSG_W-1:0] build_msg(input logic [6:0]       b,
                                                  input logic [POS_W-1:0] p);
      logic [MSG_W-1:0] m;
      int               v;
      m = '0;
      v = int'(p);
      m[MSG_W-1 -: 7] = b;
      m[MSG_W-8 -: 7] = ASCII_DOLLAR;
      for (int i = 0; i < POS_DIGITS; i++) begin
         m[(i+1)*7 +: 7] = ASCII_ZERO + 7'(v % 10);
         v = v / 10;
      end
      m[6:0] = ASCII_HASH;
      return m;
   endfunction

   logic [6:0]        btn_ascii_s;
   logic              btn_valid_s;
   logic [MSG_W-1:0]  capture_msg_s;
   logic              capture_s, full_s, pop_s, push_s, drop_s;

   logic [ENT_W-1:0]  mem_q [QUEUE_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              busy_q, overflow_q;
   logic [MSG_W-1:0]  resposta_q;

   tx_state_e         state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [ENT_W-1:0]  hold_q, hold_d;
   logic [MSG_W-1:0]  tx_msg_s;
   logic [6:0]        tx_char_s;
   logic              tx_partida_s, tx_pronto_s, tx_serial_s;

   // Priority encode: walking down from the top leaves the lowest set index.
   always_comb begin
      btn_ascii_s = 7'h00;
      for (int i = N_BUTTONS - 1; i >= 0; i--) begin
         btn_ascii_s = botoes[i] ? BTN_ASCII[i] : btn_ascii_s;
      end
   end

   assign btn_valid_s   = |botoes;
   assign capture_msg_s = build_msg(btn_ascii_s, pos);
   assign capture_s     = registra & btn_valid_s;
   assign full_s        = (count_q == CNT_W'(QUEUE_DEPTH));
   assign pop_s         = (state_q == ST_LOAD);
   // A simultaneous pop frees a slot, so a push into a full queue still fits.
   assign push_s        = capture_s & (~full_s | pop_s);
   assign drop_s        = capture_s & full_s & ~pop_s;
   assign count_d       = count_q + CNT_W'(push_s) - CNT_W'(pop_s);

   // Queue storage, pointers, fill count, capture result and status flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
         resposta_q <= '0;
      end else begin
         if (push_s) begin
            mem_q[wr_ptr_q] <= {btn_ascii_s, pos};
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (capture_s) begin
            resposta_q <= capture_msg_s;
         end
         if (drop_s) begin
            overflow_q <= 1'b1;
         end
         count_q <= count_d;
         busy_q  <= (count_d != '0) | (state_d != ST_IDLE);
      end
   end

   // Transmit sequencer: pop a message, then launch and await each character.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      case (state_q)
         ST_IDLE:  state_d = (count_q != '0) ? ST_LOAD : ST_IDLE;
         ST_LOAD: begin
            hold_d  = mem_q[rd_ptr_q];
            idx_d   = '0;
            state_d = ST_START;
         end
         ST_START: state_d = ST_WAIT;
         ST_WAIT:  state_d = tx_pronto_s ? ST_NEXT : ST_WAIT;
         ST_NEXT: begin
            if (idx_q == IDX_W'(MSG_LEN - 1)) begin
               state_d = ST_IDLE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = ST_START;
            end
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // Sequencer state, character index and holding register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
      end
   end

   assign tx_msg_s     = build_msg(hold_q[ENT_W-1 -: 7], hold_q[POS_W-1:0]);
   assign tx_partida_s = (state_q == ST_START);

   // Select the character at the current index of the held message.
   always_comb begin
      tx_char_s = ASCII_HASH;
      for (int c = 0; c < MSG_LEN; c++) begin
         tx_char_s = (idx_q == IDX_W'(c)) ? tx_msg_s[(MSG_LEN-1-c)*7 +: 7] : tx_char_s;
      end
   end

   tx_serial_7E1 u_tx (
      .clock        (clock),
      .reset        (reset),
      .partida      (tx_partida_s),
      .dados_ascii  (tx_char_s),
      .saida_serial (tx_serial_s),
      .pronto       (tx_pronto_s)
   );

`ifdef PLAY_REPORTER_CHECK_EN
   logic acertou_q, acertou_valid_q;

   // Comparison result of the latest valid capture and its update strobe.
   always_ff @(posedge clock) begin
      if (reset) begin
         acertou_q       <= 1'b0;
         acertou_valid_q <= 1'b0;
      end else begin
         acertou_valid_q <= capture_s;
         if (capture_s) begin
            acertou_q <= (expected == capture_msg_s);
         end
      end
   end

   assign acertou       = acertou_q;
   assign acertou_valid = acertou_valid_q;
`else
   logic unused_expected_s;
   assign unused_expected_s = ^expected;
   assign acertou           = 1'b0;
   assign acertou_valid     = 1'b0;
`endif

   assign serial   = tx_serial_s;
   assign busy     = busy_q;
   assign resposta = resposta_q;
   assign overflow = overflow_q;
   assign ocupacao = count_q;

endmodule

// File: tb/tb_play_reporter.sv
// tb_play_reporter: directed self-checking bench for play_reporter with the
// default parameters (9 buttons, 4-bit position, 2 digits, depth 4).
// A background receiver decodes the 7E1 line (4 clocks per bit).
module tb_play_reporter;

   localparam int  MSG_LEN = 5;
   localparam int  CPB     = 4;
`ifdef PLAY_REPORTER_CHECK_EN
   localparam bit  CHECK_ON = 1'b1;
`else
   localparam bit  CHECK_ON = 1'b0;
`endif

   logic                  clock = 1'b0;
   logic                  reset, registra;
   logic [8:0]            botoes;
   logic [3:0]            pos;
   logic [7*MSG_LEN-1:0]  expected;
   logic                  serial, busy, acertou, acertou_valid, overflow;
   logic [7*MSG_LEN-1:0]  resposta;
   logic [2:0]            ocupacao;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          rst_cnt = 0;
   logic [6:0]  rx_q[$];
   logic [9:0]  rx_frames[$];
   logic        exp_acertou = 1'b0;

   play_reporter dut (
      .clock         (clock),
      .reset         (reset),
      .registra      (registra),
      .botoes        (botoes),
      .pos           (pos),
      .expected      (expected),
      .serial        (serial),
      .busy          (busy),
      .resposta      (resposta),
      .acertou       (acertou),
      .acertou_valid (acertou_valid),
      .overflow      (overflow),
      .ocupacao      (ocupacao)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (reset === 1'b1) rst_cnt++;
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [7*MSG_LEN-1:0] str2msg(input string s);
      logic [7*MSG_LEN-1:0] m;
      byte                  b;
      m = '0;
      for (int i = 0; i < MSG_LEN; i++) begin
         b = s[i];
         m[(MSG_LEN-1-i)*7 +: 7] = b[6:0];
      end
      return m;
   endfunction

   // Serial receiver: frames spanning a reset are discarded.
   initial begin : rx_proc
      logic [9:0] f;
      int         rc;
      forever begin
         @(negedge clock);
         if (serial === 1'b0) begin
            rc = rst_cnt;
            f  = 10'd0;
            for (int b = 1; b < 10; b++) begin
               repeat (CPB) @(negedge clock);
               f[b] = serial;
            end
            if (rc == rst_cnt) begin
               check_eq("rx_parity", f[8], ^f[7:1]);
               check_eq("rx_stop", f[9], 1);
               rx_q.push_back(f[7:1]);
               rx_frames.push_back(f);
            end
         end
      end
   end

   task automatic capture(input logic [8:0] b, input logic [3:0] p, input string exp_s,
                          input string msg_s, input int occ);
      @(negedge clock);
      botoes   = b;
      pos      = p;
      expected = str2msg(exp_s);
      registra = 1'b1;
      @(posedge clock);
      #1;
      registra    = 1'b0;
      exp_acertou = CHECK_ON && (exp_s == msg_s);
      check_eq("resposta", resposta, str2msg(msg_s));
      check_eq("acertou", acertou, exp_acertou);
      check_eq("acertou_valid", acertou_valid, CHECK_ON);
      check_eq("ocupacao", ocupacao, occ);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clock);
         n++;
      end
      check_eq("idle_timeout", busy, 0);
   endtask

   task automatic check_rx(input string s);
      logic [6:0] c;
      byte        e;
      for (int i = 0; i < MSG_LEN; i++) begin
         c = (rx_q.size() > 0) ? rx_q.pop_front() : 7'h00;
         e = s[i];
         check_eq("rx_char", c, e[6:0]);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      reset = 1'b1; registra = 1'b0; botoes = '0; pos = '0; expected = '0;
      repeat (3) @(posedge clock);
      #1;
      check_eq("rst_serial", serial, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_acertou", acertou, 0);
      check_eq("rst_acertou_valid", acertou_valid, 0);
      check_eq("rst_overflow", overflow, 0);
      check_eq("rst_ocupacao", ocupacao, 0);
      check_eq("rst_resposta", resposta, 0);
      @(negedge clock);
      reset = 1'b0;

      // Single capture with start-latency check and first-frame bit pattern
      capture(9'b000100000, 4'd3, "A$03#", "A$03#", 1);
      check_eq("busy_after_push", busy, 1);
      @(posedge clock); #1;
      check_eq("valid_pulse_end", acertou_valid, 0);
      check_eq("serial_k1", serial, 1);
      @(posedge clock); #1;
      check_eq("serial_k2", serial, 1);
      @(posedge clock); #1;
      check_eq("serial_k3_start", serial, 0);
      wait_idle(600);
      check_eq("rx_count_1", rx_q.size(), 5);
      check_eq("first_frame", (rx_frames.size() > 0) ? rx_frames[0] : 10'h000, 10'b1010000010);
      check_rx("A$03#");

      // Priority (index 0 wins) and mismatch
      capture(9'b100000011, 4'd12, "A$12#", "J$12#", 1);
      wait_idle(600);
      check_eq("rx_count_2", rx_q.size(), 5);
      check_rx("J$12#");

      // Invalid capture: no buttons is a complete no-op
      @(negedge clock);
      botoes = '0; pos = 4'd12; expected = str2msg("J$12#"); registra = 1'b1;
      @(posedge clock); #1;
      registra = 1'b0;
      check_eq("inv_resposta", resposta, str2msg("J$12#"));
      check_eq("inv_acertou", acertou, exp_acertou);
      check_eq("inv_valid", acertou_valid, 0);
      check_eq("inv_ocupacao", ocupacao, 0);
      check_eq("inv_busy", busy, 0);
      repeat (10) @(negedge clock);
      check_eq("inv_serial", serial, 1);
      check_eq("inv_rx_none", rx_q.size(), 0);

      // Overflow: six captures while the first message is on the line
      capture(9'b000000010, 4'd0, "Z$00#", "Z$00#", 1);
      repeat (5) @(negedge clock);
      check_eq("ovf_popped", ocupacao, 0);
      capture(9'b000000100, 4'd15, "Y$15#", "Y$15#", 1);
      capture(9'b000001000, 4'd7,  "R$00#", "R$07#", 2);
      capture(9'b000010000, 4'd9,  "L$09#", "L$09#", 3);
      capture(9'b001000000, 4'd10, "B$10#", "B$10#", 4);
      check_eq("ovf_not_yet", overflow, 0);
      capture(9'b100000000, 4'd1,  "D$01#", "D$01#", 4);
      check_eq("ovf_set", overflow, 1);
      wait_idle(3000);
      check_eq("rx_count_ovf", rx_q.size(), 25);
      check_rx("Z$00#");
      check_rx("Y$15#");
      check_rx("R$07#");
      check_rx("L$09#");
      check_rx("B$10#");
      check_eq("ovf_sticky", overflow, 1);

      // Reset during the third character
      capture(9'b000000100, 4'd4, "Y$04#", "Y$04#", 1);
      n = 0;
      while (rx_q.size() < 2 && n < 500) begin
         @(negedge clock);
         n++;
      end
      check_eq("mid_wait_timeout", rx_q.size() >= 2, 1);
      repeat (15) @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      check_eq("mid_rst_serial", serial, 1);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_ocupacao", ocupacao, 0);
      check_eq("mid_rst_overflow", overflow, 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (50) @(negedge clock);
      check_eq("mid_serial_idle", serial, 1);
      check_eq("mid_rx_partial", rx_q.size(), 2);
      rx_q.delete();
      capture(9'b010000000, 4'd13, "C$13#", "C$13#", 1);
      wait_idle(600);
      check_eq("rx_count_post", rx_q.size(), 5);
      check_rx("C$13#");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
